// File: rtl/axis_checksum_append_pkg.sv
// Shared definitions for the AXI-Stream checksum appender: FSM encoding and default widths.
package axis_checksum_append_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_CNT_WIDTH  = 16;

    typedef enum logic {
        PASS   = 1'b0,
        APPEND = 1'b1
    } state_t;

endpackage

// File: rtl/axis_out_slot.sv
// Single registered AXI-Stream output slot: loads when free, holds while stalled.
module axis_out_slot #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  m_axis_tready,
    output logic                  free,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast
);

    assign free = !m_axis_tvalid || m_axis_tready;

    // Data only changes on a load so an idle slot keeps its last value on the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (free) begin
            m_axis_tvalid <= load;
            m_axis_tlast  <= load && load_last;
            if (load) begin
                m_axis_tdata <= load_data;
            end
        end
    end

endmodule

// File: rtl/axis_checksum_append.sv
// Passes a packet through and appends a two's-complement checksum beat carrying tlast.
module axis_checksum_append
    import axis_checksum_append_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [CNT_WIDTH-1:0]  pkt_count
);

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] sum, sum_next;
    logic                  slot_free;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  cnt_inc;
    logic                  accept;

    // Gated by reset so upstream never sees a handshake while the block is clearing.
    assign s_axis_tready = (state == PASS) && slot_free && !reset;
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PASS;
            sum       <= '0;
            pkt_count <= '0;
        end else begin
            state <= state_next;
            sum   <= sum_next;
            if (cnt_inc) begin
                pkt_count <= pkt_count + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        sum_next   = sum;
        load       = 1'b0;
        load_data  = s_axis_tdata;
        load_last  = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            PASS: begin
                if (accept) begin
                    load     = 1'b1;
                    sum_next = sum + s_axis_tdata;
                    if (s_axis_tlast) begin
                        state_next = APPEND;
                    end
                end
            end
            APPEND: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_data  = (~sum) + DATA_WIDTH'(1);
                    load_last  = 1'b1;
                    sum_next   = '0;
                    cnt_inc    = 1'b1;
                    state_next = PASS;
                end
            end
            default: state_next = PASS;
        endcase
    end

    axis_out_slot #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .load_data    (load_data),
        .load_last    (load_last),
        .m_axis_tready(m_axis_tready),
        .free         (slot_free),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast)
    );

endmodule

// File: tb/tb_axis_checksum_append.sv
// Directed bench for axis_checksum_append: packet contents, stalls, back-to-back, reset, counter wrap.
module tb_axis_checksum_append;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [15:0] pkt_count;

    logic        s_tready_n;
    logic [7:0]  m_tdata_n;
    logic        m_tvalid_n;
    logic        m_tlast_n;
    logic [3:0]  pkt_count_n;

    int          tests = 0;
    int          fails = 0;
    logic [8:0]  outq[$];
    int          low_cnt = 0;
    int          stab_err = 0;
    logic        toggle = 1'b0;

    always #5 clk = ~clk;

    axis_checksum_append dut (
        .clk          (clk),
        .reset        (reset),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .pkt_count    (pkt_count)
    );

    // Narrow-counter instance sharing the same stimulus, used to reach the wrap point quickly.
    axis_checksum_append #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_narrow (
        .clk          (clk),
        .reset        (reset),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready_n),
        .s_axis_tlast (s_tlast),
        .m_axis_tdata (m_tdata_n),
        .m_axis_tvalid(m_tvalid_n),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast_n),
        .pkt_count    (pkt_count_n)
    );

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = toggle ? ~m_tready : 1'b1;
        end
    end

    // Inputs change just after posedge, so the negedge view equals what the next edge sees.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (m_tvalid && m_tready) outq.push_back({m_tlast, m_tdata});
                if (!s_tready) low_cnt++;
                if (prev_stall && (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last))
                    stab_err++;
                prev_stall = m_tvalid && !m_tready;
                prev_data  = m_tdata;
                prev_last  = m_tlast;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        outq.delete();
        low_cnt  = 0;
        stab_err = 0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        bit done;
        done     = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (s_tready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: beat %h not accepted, required acceptance within 100 cycles", d);
        end
    endtask

    task automatic wait_out(input int n);
        for (int c = 0; c < 60 && outq.size() < n; c++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        send_beat(8'h5A, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (s_tready !== 1'b0) begin
            fails++;
            $display("FAIL reset_tready: got %b required 0", s_tready);
        end
        @(posedge clk);
        #1;
        tests++;
        if (m_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_tvalid: got %b required 0", m_tvalid);
        end
        tests++;
        if (m_tdata !== 8'h00 || m_tlast !== 1'b0) begin
            fails++;
            $display("FAIL reset_data_last: got %h/%b required 00/0", m_tdata, m_tlast);
        end
        tests++;
        if (pkt_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_pkt_count: got %0d required 0", pkt_count);
        end
        do_reset();
    endtask

    task automatic test_basic();
        logic [8:0] exp[4] = '{9'h001, 9'h002, 9'h003, 9'h1FA};
        logic [8:0] got;
        do_reset();
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b1);
        wait_out(4);
        tests++;
        if (outq.size() !== 4) begin
            fails++;
            $display("FAIL basic_count: got %0d beats required 4", outq.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < outq.size()) ? outq[i] : 9'hxxx;
            tests++;
            if (got !== exp[i]) begin
                fails++;
                $display("FAIL basic_beat%0d: got last/data %h required %h", i, got, exp[i]);
            end
        end
        tests++;
        if (pkt_count !== 16'd1) begin
            fails++;
            $display("FAIL basic_pkt_count: got %0d required 1", pkt_count);
        end
    endtask

    task automatic test_single_beat();
        logic [8:0] exp[2] = '{9'h000, 9'h100};
        logic [8:0] got;
        do_reset();
        send_beat(8'h00, 1'b1);
        wait_out(2);
        tests++;
        if (outq.size() !== 2) begin
            fails++;
            $display("FAIL single_count: got %0d beats required 2", outq.size());
        end
        for (int i = 0; i < 2; i++) begin
            got = (i < outq.size()) ? outq[i] : 9'hxxx;
            tests++;
            if (got !== exp[i]) begin
                fails++;
                $display("FAIL single_beat%0d: got last/data %h required %h", i, got, exp[i]);
            end
        end
        tests++;
        if (low_cnt !== 1) begin
            fails++;
            $display("FAIL single_tready_low: got %0d cycles required 1", low_cnt);
        end
    endtask

    task automatic test_stall();
        logic [8:0] exp[3] = '{9'h0FF, 9'h0FF, 9'h102};
        logic [8:0] got;
        do_reset();
        toggle = 1'b1;
        send_beat(8'hFF, 1'b0);
        send_beat(8'hFF, 1'b1);
        wait_out(3);
        toggle = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (outq.size() !== 3) begin
            fails++;
            $display("FAIL stall_count: got %0d beats required 3", outq.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < outq.size()) ? outq[i] : 9'hxxx;
            tests++;
            if (got !== exp[i]) begin
                fails++;
                $display("FAIL stall_beat%0d: got last/data %h required %h", i, got, exp[i]);
            end
        end
        tests++;
        if (stab_err !== 0) begin
            fails++;
            $display("FAIL stall_stability: got %0d unstable cycles required 0", stab_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp[5] = '{9'h010, 9'h1F0, 9'h020, 9'h030, 9'h1B0};
        logic [8:0] got;
        do_reset();
        send_beat(8'h10, 1'b1);
        send_beat(8'h20, 1'b0);
        send_beat(8'h30, 1'b1);
        wait_out(5);
        tests++;
        if (outq.size() !== 5) begin
            fails++;
            $display("FAIL b2b_count: got %0d beats required 5", outq.size());
        end
        for (int i = 0; i < 5; i++) begin
            got = (i < outq.size()) ? outq[i] : 9'hxxx;
            tests++;
            if (got !== exp[i]) begin
                fails++;
                $display("FAIL b2b_beat%0d: got last/data %h required %h", i, got, exp[i]);
            end
        end
        tests++;
        if (pkt_count !== 16'd2) begin
            fails++;
            $display("FAIL b2b_pkt_count: got %0d required 2", pkt_count);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [8:0] exp[2] = '{9'h007, 9'h1F9};
        logic [8:0] got;
        do_reset();
        send_beat(8'h05, 1'b0);
        send_beat(8'h06, 1'b0);
        do_reset();
        send_beat(8'h07, 1'b1);
        wait_out(2);
        tests++;
        if (outq.size() !== 2) begin
            fails++;
            $display("FAIL midreset_count: got %0d beats required 2", outq.size());
        end
        for (int i = 0; i < 2; i++) begin
            got = (i < outq.size()) ? outq[i] : 9'hxxx;
            tests++;
            if (got !== exp[i]) begin
                fails++;
                $display("FAIL midreset_beat%0d: got last/data %h required %h", i, got, exp[i]);
            end
        end
        tests++;
        if (pkt_count !== 16'd1) begin
            fails++;
            $display("FAIL midreset_pkt_count: got %0d required 1", pkt_count);
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        for (int p = 0; p < 15; p++) send_beat(8'h11, 1'b1);
        wait_out(30);
        tests++;
        if (pkt_count_n !== 4'd15) begin
            fails++;
            $display("FAIL wrap_preload_narrow: got %0d required 15", pkt_count_n);
        end
        send_beat(8'h22, 1'b1);
        wait_out(32);
        tests++;
        if (pkt_count_n !== 4'd0) begin
            fails++;
            $display("FAIL wrap_narrow: got %0d required 0", pkt_count_n);
        end
        tests++;
        if (pkt_count !== 16'd16) begin
            fails++;
            $display("FAIL wrap_wide: got %0d required 16", pkt_count);
        end
        tests++;
        if (outq.size() !== 32) begin
            fails++;
            $display("FAIL wrap_beats: got %0d beats required 32", outq.size());
        end
    endtask

    initial begin
        do_reset();
        test_basic();
        test_reset();
        test_single_beat();
        test_stall();
        test_back_to_back();
        test_reset_mid_packet();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
